tdc_shot_sequencer: RTL and testbench
=====================================

TDC_SHOT_SEQUENCER -- requirements
Module: tdc_shot_sequencer

Interface
REQ-001 SHALL have ports (name dir width meaning):
- clk  in  1: 250 MHz logic clock.
- rst  in  1: synchronous, active-high reset.
REQ-002 SHALL have configuration inputs:
- cfg_en  in  1: run enable.
- cfg_period  in  20: shot period in clk cycles, legal range >=2.
- cfg_shots  in  16: shots per frame, equal to histogram batch, legal >=1.
- cfg_timeout  in  16: result-wait limit in clk cycles.
REQ-003 SHALL have TDC-side ports:
- TDC_start  out  1: one-cycle shot trigger to tdc_top.
- busy  in  1: tdc_top measurement in progress.
REQ-004 SHALL have histogram-side ports:
- HIS_Odata  in  15: frame depth result.
- HIS_Ovalid  in  1: result valid.
- HIS_Oready  out  1: sequencer accepts result.
REQ-005 SHALL have frame output ports:
- frame_data  out  15: frame result.
- frame_err  out  1: frame timed out.
- frame_valid  out  1: frame output valid.
- frame_ready  in  1: downstream accepts frame.
REQ-006 SHALL have status outputs:
- shot_cnt  out  16: shots completed in current frame.
- frame_cnt  out  16: frames delivered, wraps modulo 2^16.
- seq_busy  out  1: state is not IDLE.
- err_timeout  out  1: sticky timeout flag.

Function
REQ-007 SHALL implement FSM states IDLE, FIRE, WAIT, RESULT, OUT.
REQ-008 IDLE: when cfg_en=1, cfg_shots!=0 and cfg_period>=2, SHALL latch cfg_period/cfg_shots/cfg_timeout, clear shot_cnt, and go to FIRE next cycle; otherwise remain in IDLE.
REQ-009 FIRE: TDC_start=1 for exactly this one cycle; period counter loads 0; next state WAIT.
REQ-010 WAIT: period counter increments each cycle; a shot completes on the first cycle where period counter == latched period-1 and busy=0.
REQ-011 With busy=0, consecutive TDC_start rising edges SHALL be exactly latched period cycles apart; busy=1 at period end extends WAIT until busy falls, with the counter saturating.
REQ-012 On shot completion, shot_cnt SHALL increment. Next state:
- cfg_en=0: IDLE, frame discarded.
- shot_cnt+1 == latched shots: RESULT.
- otherwise: FIRE.
REQ-013 RESULT: HIS_Oready=1. On HIS_Ovalid=1, SHALL capture HIS_Odata into frame_data, set frame_err=0, and go to OUT.
REQ-014 RESULT timeout counter SHALL start at 0 on entry. If it reaches latched cfg_timeout without HIS_Ovalid, SHALL set frame_data=15'h7FFF, frame_err=1, err_timeout=1, and go to OUT. cfg_timeout=0 SHALL mean wait forever.
REQ-015 HIS_Ovalid in the same cycle the timeout is reached SHALL take priority; the data is captured and no error is raised.
REQ-016 OUT: frame_valid=1 and frame_data/frame_err SHALL hold stable until frame_ready=1. On handshake:
- frame_cnt increments.
- shot_cnt clears.
- next state FIRE if cfg_en=1, else IDLE.
REQ-017 cfg_en changes SHALL NOT abort RESULT or OUT; configuration inputs SHALL be ignored outside IDLE.
REQ-018 err_timeout SHALL clear only on rst; HIS_Oready=0 in every state except RESULT.

Reset
REQ-019 rst=1 at any clock edge, including mid-frame, SHALL force the following next cycle:
- state IDLE.
- TDC_start=0, HIS_Oready=0, frame_valid=0.
- frame_data=0, frame_err=0.
- shot_cnt=0, frame_cnt=0.
- seq_busy=0, err_timeout=0.
- all internal counters 0.
No TDC_start SHALL be emitted in the reset cycle.

Structure
REQ-020 Package tdc_seq_pkg SHALL hold the state enum and width constants: PERIOD_W=20, SHOT_W=16, DATA_W=15, and TIMEOUT_DATA=15'h7FFF.
REQ-021 A sub-module tdc_seq_timer (loadable up-counter with saturate and terminal-compare) SHALL be used for both the period counter and the timeout counter.

Verification
REQ-022 Directed scenarios:
- period=641, shots=3, busy=0, HIS_Ovalid pulse with 15'h1234 after 3rd shot: 3 TDC_start pulses 641 cycles apart; frame_data=15'h1234, frame_err=0, frame_cnt=1.
- period=10, busy held high 25 cycles after the first TDC_start: second TDC_start delayed until the cycle after busy falls, not at cycle 10.
- timeout=50, no HIS_Ovalid: frame_data=15'h7FFF, frame_err=1, err_timeout=1, 50 cycles after RESULT entry.
- frame_ready=0 for 20 cycles in OUT: frame_valid and frame_data stable throughout; no TDC_start emitted until handshake.
- cfg_en dropped during shot 2 of 4: returns to IDLE at shot 2 completion; no frame_valid; frame_cnt unchanged.
- rst asserted in WAIT with shot_cnt=5: all outputs at reset values next cycle; cfg_shots=0 in IDLE keeps FSM in IDLE.

Source files
------------

// File: rtl/tdc_seq_pkg.sv
// Shared widths, constants and FSM state encoding for the TDC shot sequencer.
package tdc_seq_pkg;

  localparam int PERIOD_W  = 20;
  localparam int SHOT_W    = 16;
  localparam int DATA_W    = 15;
  localparam int TIMEOUT_W = 16;

  localparam logic [DATA_W-1:0] TIMEOUT_DATA = 15'h7FFF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FIRE   = 3'd1,
    ST_WAIT   = 3'd2,
    ST_RESULT = 3'd3,
    ST_OUT    = 3'd4
  } state_t;

endpackage

// File: rtl/tdc_seq_timer.sv
// Loadable up-counter: clears on load, counts while enabled, parks on its terminal value.
module tdc_seq_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic         at_term
);

  logic [W-1:0] count;

  assign at_term = (count == term);

  // NOTE: sequential state is always updated with <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (en && !at_term) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/tdc_shot_sequencer.sv
// Fires TDC shots at a fixed period, gathers one histogram result per frame and hands it downstream.
module tdc_shot_sequencer
  import tdc_seq_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_en,
  input  logic [PERIOD_W-1:0]  cfg_period,
  input  logic [SHOT_W-1:0]    cfg_shots,
  input  logic [TIMEOUT_W-1:0] cfg_timeout,
  output logic                 TDC_start,
  input  logic                 busy,
  input  logic [DATA_W-1:0]    HIS_Odata,
  input  logic                 HIS_Ovalid,
  output logic                 HIS_Oready,
  output logic [DATA_W-1:0]    frame_data,
  output logic                 frame_err,
  output logic                 frame_valid,
  input  logic                 frame_ready,
  output logic [SHOT_W-1:0]    shot_cnt,
  output logic [15:0]          frame_cnt,
  output logic                 seq_busy,
  output logic                 err_timeout
);

  state_t state, state_nx;

  logic [PERIOD_W-1:0]  lat_period;
  logic [SHOT_W-1:0]    lat_shots;
  logic [TIMEOUT_W-1:0] lat_timeout;

  logic start_ok, period_at_term, to_at_term, shot_done, timed_out, last_shot;

  assign start_ok  = cfg_en && (cfg_shots != '0) && (cfg_period >= PERIOD_W'(2));
  assign shot_done = (state == ST_WAIT) && period_at_term && !busy;
  assign last_shot = ((shot_cnt + 1'b1) == lat_shots);
  // A zero timeout disables the limit; a same-cycle valid beats the timeout.
  assign timed_out = (state == ST_RESULT) && (lat_timeout != '0) && to_at_term && !HIS_Ovalid;

  // The period counter reads 0 during FIRE, so a shot spans exactly lat_period cycles.
  tdc_seq_timer #(.W(PERIOD_W)) u_period_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (state_nx == ST_FIRE),
    .en      ((state == ST_FIRE) || (state == ST_WAIT)),
    .term    (lat_period - 1'b1),
    .at_term (period_at_term)
  );

  tdc_seq_timer #(.W(TIMEOUT_W)) u_timeout_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (state != ST_RESULT),
    .en      (state == ST_RESULT),
    .term    (lat_timeout),
    .at_term (to_at_term)
  );

  always_comb begin
    // NOTE: default assignment first so no path through the case leaves state_nx unassigned (no latch).
    state_nx = state;
    case (state)
      ST_IDLE:   if (start_ok) state_nx = ST_FIRE;
      ST_FIRE:   state_nx = ST_WAIT;
      ST_WAIT: begin
        if (shot_done) begin
          if (!cfg_en)        state_nx = ST_IDLE;
          else if (last_shot) state_nx = ST_RESULT;
          else                state_nx = ST_FIRE;
        end
      end
      ST_RESULT: if (HIS_Ovalid || timed_out) state_nx = ST_OUT;
      ST_OUT:    if (frame_ready) state_nx = cfg_en ? ST_FIRE : ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      lat_period  <= '0;
      lat_shots   <= '0;
      lat_timeout <= '0;
      shot_cnt    <= '0;
      frame_cnt   <= '0;
      frame_data  <= '0;
      frame_err   <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        ST_IDLE: begin
          if (start_ok) begin
            lat_period  <= cfg_period;
            lat_shots   <= cfg_shots;
            lat_timeout <= cfg_timeout;
            shot_cnt    <= '0;
          end
        end
        ST_WAIT: if (shot_done) shot_cnt <= shot_cnt + 1'b1;
        ST_RESULT: begin
          if (HIS_Ovalid) begin
            frame_data <= HIS_Odata;
            frame_err  <= 1'b0;
          end else if (timed_out) begin
            frame_data  <= TIMEOUT_DATA;
            frame_err   <= 1'b1;
            err_timeout <= 1'b1;
          end
        end
        ST_OUT: begin
          if (frame_ready) begin
            frame_cnt <= frame_cnt + 1'b1;
            shot_cnt  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // The trigger is suppressed while reset is asserted so no shot leaks out of the reset cycle.
  assign TDC_start   = (state == ST_FIRE) && !rst;
  assign HIS_Oready  = (state == ST_RESULT);
  assign frame_valid = (state == ST_OUT);
  assign seq_busy    = (state != ST_IDLE);

endmodule

// File: tb/tb_tdc_shot_sequencer.sv
// Self-checking bench: IDLE-start vector table, directed frame scenarios and randomized frames vs a timeline model.
module tb_tdc_shot_sequencer;
  import tdc_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_en;
  logic [19:0] cfg_period;
  logic [15:0] cfg_shots;
  logic [15:0] cfg_timeout;
  logic        TDC_start;
  logic        busy;
  logic [14:0] HIS_Odata;
  logic        HIS_Ovalid;
  logic        HIS_Oready;
  logic [14:0] frame_data;
  logic        frame_err;
  logic        frame_valid;
  logic        frame_ready;
  logic [15:0] shot_cnt;
  logic [15:0] frame_cnt;
  logic        seq_busy;
  logic        err_timeout;

  tdc_shot_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_en      (cfg_en),
    .cfg_period  (cfg_period),
    .cfg_shots   (cfg_shots),
    .cfg_timeout (cfg_timeout),
    .TDC_start   (TDC_start),
    .busy        (busy),
    .HIS_Odata   (HIS_Odata),
    .HIS_Ovalid  (HIS_Ovalid),
    .HIS_Oready  (HIS_Oready),
    .frame_data  (frame_data),
    .frame_err   (frame_err),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .shot_cnt    (shot_cnt),
    .frame_cnt   (frame_cnt),
    .seq_busy    (seq_busy),
    .err_timeout (err_timeout)
  );

  always #2 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;
  int cyc      = 0;

  // Run configuration and per-frame stimulus plan used by the timeline model.
  int          P, N, T;
  int          b_arr[16];
  int          d_v, r_v;
  logic [14:0] dat_v;
  bit          scramble;
  int          exp_frames;
  bit          exp_err;
  int          obs_starts[$];
  int          last_e, last_rise;
  logic [14:0] last_data;
  logic        last_err;

  typedef struct {
    logic        en;
    logic [19:0] period;
    logic [15:0] shots;
    logic        exp_run;
  } idle_vec_t;

  idle_vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_tdc_start"},   TDC_start,   0);
    check({tag, "_his_oready"},  HIS_Oready,  0);
    check({tag, "_frame_valid"}, frame_valid, 0);
    check({tag, "_frame_data"},  frame_data,  0);
    check({tag, "_frame_err"},   frame_err,   0);
    check({tag, "_shot_cnt"},    shot_cnt,    0);
    check({tag, "_frame_cnt"},   frame_cnt,   0);
    check({tag, "_seq_busy"},    seq_busy,    0);
    check({tag, "_err_timeout"}, err_timeout, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1; cfg_en = 1'b0; busy = 1'b0; HIS_Ovalid = 1'b0; frame_ready = 1'b0;
    step();
    rst = 1'b0;
    exp_frames = 0;
    exp_err    = 1'b0;
  endtask

  task automatic start_run(input int p, input int n, input int t);
    P = p; N = n; T = t;
    cfg_period = 20'(p); cfg_shots = 16'(n); cfg_timeout = 16'(t); cfg_en = 1'b1;
  endtask

  // A shot lasts the period, or until two cycles past the busy burst that follows its trigger.
  function automatic int gap(input int b);
    return (b + 2 > P) ? b + 2 : P;
  endfunction

  // Drives one frame from the model's timeline (first trigger at s1) and compares observed events.
  task automatic do_frame(input int s1, output int nxt);
    int   s[16];
    int   e, o, done, rise, bad_ready, bad_out;
    bit   timed;
    logic [14:0] exp_data;
    s[0] = s1;
    for (int i = 1; i < N; i++) s[i] = s[i-1] + gap(b_arr[i-1]);
    e        = s[N-1] + gap(b_arr[N-1]);
    timed    = (T != 0) && (d_v < 0 || d_v > T);
    o        = timed ? e + T + 1 : e + d_v + 1;
    exp_data = timed ? TIMEOUT_DATA : dat_v;
    done     = o + r_v;
    rise = -1; bad_ready = 0; bad_out = 0;
    obs_starts.delete();
    while (cyc <= done) begin
      busy = 1'b0;
      for (int i = 0; i < N; i++) if (cyc > s[i] && cyc <= s[i] + b_arr[i]) busy = 1'b1;
      HIS_Ovalid  = (d_v >= 0) && (cyc == e + d_v);
      HIS_Odata   = HIS_Ovalid ? dat_v : 15'($urandom);
      frame_ready = (cyc == done);
      cfg_en      = (scramble && cyc >= e && cyc < done) ? 1'($urandom) : 1'b1;
      if (scramble && cyc >= s[0]) begin
        cfg_period  = 20'($urandom_range(0, 20));
        cfg_shots   = 16'($urandom_range(0, 5));
        cfg_timeout = 16'($urandom_range(0, 30));
      end
      if (TDC_start) obs_starts.push_back(cyc);
      if (frame_valid && rise < 0) rise = cyc;
      if (HIS_Oready !== (cyc >= e && cyc < o)) bad_ready++;
      if (cyc >= o && (frame_valid !== 1'b1 || frame_data !== exp_data ||
                       frame_err !== timed || TDC_start !== 1'b0)) bad_out++;
      if (cyc == o) check("shot_cnt_at_out", shot_cnt, N);
      if (cyc == done) begin last_data = frame_data; last_err = frame_err; end
      step();
    end
    busy = 1'b0; HIS_Ovalid = 1'b0; frame_ready = 1'b0; cfg_en = 1'b1;
    cfg_period = 20'(P); cfg_shots = 16'(N); cfg_timeout = 16'(T);
    exp_frames++;
    exp_err = exp_err | timed;
    last_e = e; last_rise = rise;
    check("start_count", obs_starts.size(), N);
    for (int i = 0; i < N && i < obs_starts.size(); i++)
      check("start_offset", obs_starts[i] - s1, s[i] - s1);
    check("out_entry",    rise - s1, o - s1);
    check("ready_window", bad_ready, 0);
    check("out_hold",     bad_out, 0);
    check("frame_data",   last_data, exp_data);
    check("frame_err",    last_err, timed);
    check("frame_cnt",    frame_cnt, exp_frames & 16'hFFFF);
    check("shot_cnt_clr", shot_cnt, 0);
    check("err_sticky",   err_timeout, exp_err);
    nxt = cyc;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int s1, seen, g, fv, ts;
    rst = 1'b1; cfg_en = 1'b0; cfg_period = '0; cfg_shots = '0; cfg_timeout = '0;
    busy = 1'b0; HIS_Odata = '0; HIS_Ovalid = 1'b0; frame_ready = 1'b0; scramble = 1'b0;

    // IDLE start qualification: {cfg_en, cfg_period, cfg_shots, expect FIRE next cycle}.
    vecs[0] = '{1'b1, 20'd2,       16'd1,      1'b1};
    vecs[1] = '{1'b1, 20'd1,       16'd4,      1'b0};
    vecs[2] = '{1'b1, 20'd0,       16'd4,      1'b0};
    vecs[3] = '{1'b1, 20'd5,       16'd0,      1'b0};
    vecs[4] = '{1'b0, 20'd5,       16'd4,      1'b0};
    vecs[5] = '{1'b1, 20'hFFFFF,   16'hFFFF,   1'b1};
    vecs[6] = '{1'b1, 20'd3,       16'd1,      1'b1};

    do_reset();
    check_reset_outs("reset");

    foreach (vecs[i]) begin
      do_reset();
      cfg_en = vecs[i].en; cfg_period = vecs[i].period; cfg_shots = vecs[i].shots; cfg_timeout = '0;
      step();
      check("idle_vec_fire",  TDC_start, vecs[i].exp_run);
      check("idle_vec_busy",  seq_busy,  vecs[i].exp_run);
      step();
      check("idle_vec_hold",  seq_busy,  vecs[i].exp_run);
      check("idle_vec_nofire", TDC_start, 0);
    end

    // Long period, idle TDC, result after third shot, downstream stalls 20 cycles in OUT.
    do_reset();
    start_run(641, 3, 0);
    for (int i = 0; i < 3; i++) b_arr[i] = 0;
    d_v = 3; r_v = 20; dat_v = 15'h1234;
    do_frame(cyc + 1, s1);
    check("p641_gap", (obs_starts.size() >= 2) ? obs_starts[1] - obs_starts[0] : -1, 641);
    check("p641_data", last_data, 15'h1234);
    check("p641_frames", frame_cnt, 1);

    // Busy held 25 cycles after the first trigger stretches the shot past the period.
    do_reset();
    start_run(10, 2, 0);
    b_arr[0] = 25; b_arr[1] = 0;
    d_v = 0; r_v = 0; dat_v = 15'h0ABC;
    do_frame(cyc + 1, s1);
    check("busy_ext_gap", (obs_starts.size() >= 2) ? obs_starts[1] - obs_starts[0] : -1, 27);

    // No histogram result: timeout after 50 counted cycles, visible in OUT the cycle after.
    do_reset();
    start_run(4, 1, 50);
    b_arr[0] = 0;
    d_v = -1; r_v = 2; dat_v = 15'h0;
    do_frame(cyc + 1, s1);
    check("to_data",    last_data, 15'h7FFF);
    check("to_err",     last_err, 1);
    check("to_sticky",  err_timeout, 1);
    check("to_latency", last_rise - last_e, 51);

    // Enable dropped during shot 2 of 4: back to IDLE at that shot's completion.
    do_reset();
    start_run(8, 4, 0);
    step();
    seen = 0; g = 0;
    while (seen < 2 && g < 100) begin
      if (TDC_start) seen++;
      if (seen < 2) begin step(); g++; end
    end
    check("drop_second_start", seen, 2);
    cfg_en = 1'b0;
    repeat (7) step();
    check("drop_still_wait", seq_busy, 1);
    step();
    check("drop_idle", seq_busy, 0);
    fv = 0; ts = 0;
    repeat (20) begin fv += int'(frame_valid); ts += int'(TDC_start); step(); end
    check("drop_no_frame", fv, 0);
    check("drop_no_start", ts, 0);
    check("drop_frame_cnt", frame_cnt, 0);

    // Reset in WAIT with five shots done.
    do_reset();
    start_run(4, 8, 0);
    step();
    repeat (21) step();
    check("pre_rst_shots", shot_cnt, 5);
    check("pre_rst_busy",  seq_busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_outs("midrst");

    // Randomized continuous runs with configuration scrambled outside IDLE.
    for (int run = 0; run < 3; run++) begin
      do_reset();
      check("run_rst_sticky", err_timeout, 0);
      start_run($urandom_range(2, 12), $urandom_range(1, 4), $urandom_range(0, 20));
      scramble = 1'b1;
      s1 = cyc + 1;
      for (int f = 0; f < 5; f++) begin
        for (int i = 0; i < N; i++) b_arr[i] = $urandom_range(0, P + 3);
        if (T == 0) d_v = $urandom_range(0, 10);
        else        d_v = ($urandom_range(0, 3) == 0) ? -1 : $urandom_range(0, T + 5);
        r_v   = $urandom_range(0, 4);
        dat_v = 15'($urandom);
        do_frame(s1, s1);
      end
      scramble = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
